adder_seq_ctrl: RTL and testbench



---
 rtl/adder_seq_pkg.sv | 14 +
 rtl/adder_word.sv | 14 +
 rtl/adder_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_adder_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types for the multi-precision add/subtract sequencer.
package adder_seq_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/adder_word.sv
// Combinational 32-bit a+b+cin stage wrapping the shared ripple-carry adder.
module adder_word
  import adder_seq_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cin_i};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Streams a WORDS x 32-bit add/subtract through one word adder, LSW first.
// Optional completed-operation counter: define ADDER_SEQ_STATS_EN.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sub,
  input  logic                    in_cin,
  input  logic [WORDS*WORD_W-1:0] in_a,
  input  logic [WORDS*WORD_W-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] out_sum,
  output logic                    out_cout,
  output logic                    out_of
`ifdef ADDER_SEQ_STATS_EN
  ,
  output logic [15:0]             ops_done
`endif
);

  localparam int unsigned OP_W  = WORDS * WORD_W;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_q;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic [OP_W-1:0]  sum_q;
  logic             sub_q;
  logic             carry_q;
  logic             valid_q;
  logic             cout_q;
  logic             of_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  word_t a_word;
  word_t b_word;
  word_t sum_word;
  logic  cout_word;
  logic  last_word;

  // Current word slice; B is inverted for subtract, the +1 comes from the initial carry.
  always_comb begin
    a_word    = a_q[idx_q*WORD_W +: WORD_W];
    b_word    = b_q[idx_q*WORD_W +: WORD_W] ^ {WORD_W{sub_q}};
    idx_d     = idx_q + IDX_W'(1);
    last_word = (idx_q == LAST_IDX);
  end

  adder_word u_adder_word (
    .a_i    (a_word),
    .b_i    (b_word),
    .cin_i  (carry_q),
    .sum_o  (sum_word),
    .cout_o (cout_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      cout_q  <= 1'b0;
      of_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            sub_q   <= in_sub;
            carry_q <= in_sub | in_cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*WORD_W +: WORD_W] <= sum_word;
          carry_q <= cout_word;
          idx_q   <= idx_d;
          // Final carry and sign overflow are captured from the MSW pass.
          if (last_word) begin
            cout_q  <= cout_word;
            of_q    <= (a_word[WORD_W-1] == b_word[WORD_W-1]) &&
                       (sum_word[WORD_W-1] != a_word[WORD_W-1]);
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_of    = of_q;

`ifdef ADDER_SEQ_STATS_EN
  logic [15:0] ops_cnt_q;

  // Saturating count of output handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_cnt_q <= '0;
    end else if (valid_q && out_ready && (ops_cnt_q != 16'hFFFF)) begin
      ops_cnt_q <= ops_cnt_q + 16'd1;
    end
  end

  assign ops_done = ops_cnt_q;
`else
  // Statistics disabled: no completed-operation counter is built.
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl with a scoreboard queue of expected results.
module tb_adder_seq_ctrl;

  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = WORDS * 32;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_sub;
  logic         in_cin;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         out_of;
`ifdef ADDER_SEQ_STATS_EN
  logic [15:0]  ops_done;
`endif

  int   vec_cnt;
  int   err_cnt;
  exp_t sb[$];

  adder_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_of    (out_of)
`ifdef ADDER_SEQ_STATS_EN
    ,
    .ops_done  (ops_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full-width reference: one 129-bit addition, independent of the word loop.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic sub, input logic cin);
    logic [N:0]   full;
    logic [N-1:0] bp;
    exp_t         e;
    bp    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bp} + {{N{1'b0}}, (sub | cin)};
    e.sum  = full[N-1:0];
    e.cout = full[N];
    e.ovf  = (a[N-1] == bp[N-1]) && (full[N-1] != a[N-1]);
    return e;
  endfunction

  function automatic logic [N-1:0] rnd_op();
    logic [N-1:0] v;
    for (int i = 0; i < int'(WORDS); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Wait for in_ready, present one request for one accept edge; returns at the next negedge.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                      input logic cin, input exp_t e, input bit push);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the first negedge after the accept edge; out_valid must rise at the fifth.
  task automatic wait_out();
    int n;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, WORDS + 1);
  endtask

  task automatic recv(input int hold);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("out_sum", out_sum, e.sum);
    chk("out_cout", out_cout, e.cout);
    chk("out_of", out_of, e.ovf);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_sum", out_sum, e.sum);
      chk("hold_cout", out_cout, e.cout);
      chk("hold_of", out_of, e.ovf);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", out_valid, 1'b0);
    chk("post_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         s;
    logic         c;
    exp_t         e;

    vec_cnt = 0; err_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_sub = 1'b0; in_cin = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sum", out_sum, '0);
    chk("rst_cout", out_cout, 1'b0);
    chk("rst_of", out_of, 1'b0);
    chk("rst_ready_idle", in_ready, 1'b1);

    // 2^128-1 + 1 wraps to zero with carry out
    e.sum = '0; e.cout = 1'b1; e.ovf = 1'b0;
    send({N{1'b1}}, 128'd1, 1'b0, 1'b0, e, 1'b1);
    chk("run_ready", in_ready, 1'b0);
    wait_out();
    recv(0);

    // Max positive + 1 overflows into the sign bit
    e.sum = {1'b1, {(N-1){1'b0}}}; e.cout = 1'b0; e.ovf = 1'b1;
    send({1'b0, {(N-1){1'b1}}}, 128'd1, 1'b0, 1'b0, e, 1'b1);
    wait_out();
    recv(0);

    // 5 - 7 with in_cin set, which subtract must ignore
    e.sum = {{(N-1){1'b1}}, 1'b0}; e.cout = 1'b0; e.ovf = 1'b0;
    send(128'd5, 128'd7, 1'b1, 1'b1, e, 1'b1);
    wait_out();
    recv(0);

    // Random add/subtract mix against the full-width model
    for (int i = 0; i < 6; i++) begin
      a = rnd_op(); b = rnd_op(); s = 1'($urandom_range(1)); c = 1'($urandom_range(1));
      if (i == 0) b = a;
      send(a, b, s, c, model(a, b, s, c), 1'b1);
      wait_out();
      recv(0);
    end

    // Back-pressure in DONE with a pending request held on the input
    a = rnd_op(); b = rnd_op();
    send(a, b, 1'b0, 1'b1, model(a, b, 1'b0, 1'b1), 1'b1);
    wait_out();
    a = rnd_op(); b = rnd_op();
    in_a = a; in_b = b; in_sub = 1'b1; in_cin = 1'b0; in_valid = 1'b1;
    sb.push_back(model(a, b, 1'b1, 1'b0));
    recv(3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pending_accepted", in_ready, 1'b0);
    wait_out();
    recv(0);

    // Reset while RUN is on word 2 abandons the operation
    a = rnd_op(); b = rnd_op();
    send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0), 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_sum", out_sum, '0);
    chk("mid_rst_cout", out_cout, 1'b0);
    chk("mid_rst_of", out_of, 1'b0);
    repeat (6) @(negedge clk);
    chk("mid_rst_no_valid", out_valid, 1'b0);
    a = rnd_op(); b = rnd_op();
    send(a, b, 1'b1, 1'b0, model(a, b, 1'b1, 1'b0), 1'b1);
    wait_out();
    recv(0);

`ifdef ADDER_SEQ_STATS_EN
    // Completed-operation counter and saturation
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ops_rst", ops_done, 16'd0);
    for (int i = 0; i < 3; i++) begin
      a = rnd_op(); b = rnd_op();
      send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0), 1'b1);
      wait_out();
      recv(0);
    end
    chk("ops_three", ops_done, 16'd3);
    force dut.ops_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.ops_cnt_q;
    a = rnd_op(); b = rnd_op();
    send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0), 1'b1);
    wait_out();
    recv(0);
    chk("ops_saturate", ops_done, 16'hFFFF);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
